// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of a classic 5-stage in-order pipeline. The block
// also provides operand forwarding for EX and load-use hazard detection.
//
// Each rising edge captures the ID instruction into the EX registers. If the
// instruction is killed (flush), must wait (stall) or is absent (!id_valid),
// a bubble is loaded instead. Captured operands already include the
// register-file write-then-read bypass from the WB stage. In EX the operands
// are forwarded combinationally from the EX/MEM and MEM/WB results.
//
// Valid semantics: ex_valid marks the EX slot as holding a real instruction.
// When ex_valid=0 the EX fields are zero. ex_opA/ex_opB still resolve from
// those fields and are ignored downstream. There is no ready path. stall is
// the only back-pressure and tells IF/ID to hold its contents.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt, id_dst       ID source registers and destination register
//   id_busA, id_busB           register-file read data for id_rs / id_rt
//   id_imm                     extended immediate
//   id_ctrl                    [0] RegWr, [1] MemRd, [2] MemWr, [9:3] passed through
//   flush                      kill the ID instruction (branch/jump redirect)
//   mem_regwr/addr/data        EX/MEM result used for forwarding
//   wb_regwr/addr/data         MEM/WB result (also the register-file write port)
//   stall                      load-use hazard; hold PC and IF/ID
//   ex_valid, ex_rs, ex_rt,
//   ex_dst, ex_imm, ex_ctrl    registered ID/EX fields
//   ex_opA, ex_opB             forwarded ALU operands
//   ex_fwdA, ex_fwdB           operand source: 0 captured, 1 mem, 2 wb, 3 zero
// ----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [31:0] id_busA,
    input  logic [31:0] id_busB,
    input  logic [31:0] id_imm,
    input  logic [9:0]  id_ctrl,
    input  logic        flush,
    input  logic        mem_regwr,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        wb_regwr,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        ex_valid,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst,
    output logic [31:0] ex_imm,
    output logic [9:0]  ex_ctrl,
    output logic [31:0] ex_opA,
    output logic [31:0] ex_opB,
    output logic [1:0]  ex_fwdA,
    output logic [1:0]  ex_fwdB
);

    localparam logic [1:0] SRC_CAP  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_WB   = 2'd2;
    localparam logic [1:0] SRC_ZERO = 2'd3;

    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic [31:0] id_opA;
    logic [31:0] id_opB;
    logic        load_bubble;

    // Register-file write-then-read gap: a WB write in the same cycle as the
    // ID read is not yet visible on the read bus, so it is taken directly.
    // Register 0 reads as zero and is never bypassed.
    function automatic logic [31:0] rf_bypass(
        input logic [4:0]  r,
        input logic [31:0] bus,
        input logic        wr,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        if (r == 5'd0)
            return 32'd0;
        else if (wr && (wa == r))
            return wd;
        else
            return bus;
    endfunction

    // EX forwarding: {source, data}. The mem match is checked before the wb
    // match because the EX/MEM result is younger. No match is possible on
    // register 0 because that case is resolved first.
    function automatic logic [33:0] ex_forward(
        input logic [4:0]  r,
        input logic [31:0] cap,
        input logic        mwr,
        input logic [4:0]  ma,
        input logic [31:0] md,
        input logic        wwr,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        if (r == 5'd0)
            return {SRC_ZERO, 32'd0};
        else if (mwr && (ma == r))
            return {SRC_MEM, md};
        else if (wwr && (wa == r))
            return {SRC_WB, wd};
        else
            return {SRC_CAP, cap};
    endfunction

    // Load-use hazard: a load in EX whose destination is read by ID.
    // The result is not available until the load reaches WB.
    always_comb begin
        stall = id_valid && ex_valid && ex_ctrl[1] && (ex_dst != 5'd0) &&
                ((ex_dst == id_rs) || (ex_dst == id_rt));
    end

    assign load_bubble = flush || stall || !id_valid;
    assign id_opA      = rf_bypass(id_rs, id_busA, wb_regwr, wb_addr, wb_data);
    assign id_opB      = rf_bypass(id_rt, id_busB, wb_regwr, wb_addr, wb_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_rs    <= 5'd0;
            ex_rt    <= 5'd0;
            ex_dst   <= 5'd0;
            ex_imm   <= 32'd0;
            ex_ctrl  <= 10'd0;
            cap_a    <= 32'd0;
            cap_b    <= 32'd0;
        end else if (load_bubble) begin
            ex_valid <= 1'b0;
            ex_rs    <= 5'd0;
            ex_rt    <= 5'd0;
            ex_dst   <= 5'd0;
            ex_imm   <= 32'd0;
            ex_ctrl  <= 10'd0;
            cap_a    <= 32'd0;
            cap_b    <= 32'd0;
        end else begin
            ex_valid <= 1'b1;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_dst   <= id_dst;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_ctrl;
            cap_a    <= id_opA;
            cap_b    <= id_opB;
        end
    end

    always_comb begin
        {ex_fwdA, ex_opA} = ex_forward(ex_rs, cap_a, mem_regwr, mem_addr, mem_data,
                                       wb_regwr, wb_addr, wb_data);
        {ex_fwdB, ex_opB} = ex_forward(ex_rt, cap_b, mem_regwr, mem_addr, mem_data,
                                       wb_regwr, wb_addr, wb_data);
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_rs, id_rt, id_dst  in  5 each  source registers and resolved destination register of the ID instruction.
REQ-005 id_busA, id_busB  in  32 each  register-file read data for id_rs / id_rt.
REQ-006 id_imm  in  32  sign/zero-extended immediate.
REQ-007 id_ctrl  in  10  control bundle; bit0 RegWr, bit1 MemRd, bit2 MemWr, bits9:3 passed through unchanged.
REQ-008 flush  in  1  branch/jump redirect; kill the ID instruction.
REQ-009 mem_regwr, mem_addr(5), mem_data(32)  in  EX/MEM result for forwarding.
REQ-010 wb_regwr, wb_addr(5), wb_data(32)  in  MEM/WB result; same signals drive the register-file write port.
REQ-011 stall  out  1  combinational; holds PC and IF/ID when 1.
REQ-012 ex_valid  out  1; ex_rs, ex_rt, ex_dst  out  5; ex_imm  out  32; ex_ctrl  out  10  registered ID/EX fields.
REQ-013 ex_opA, ex_opB  out  32  forwarded ALU operands (combinational from registered state plus mem_*/wb_*).
REQ-014 ex_fwdA, ex_fwdB  out  2  operand source: 0 captured, 1 mem, 2 wb, 3 zero-register.

Function
REQ-015 Capture (ID->EX register) SHALL occur each rising edge; operand A captured = 0 if id_rs==0, else wb_data if wb_regwr & wb_addr==id_rs, else id_busA; operand B identical using id_rt/id_busB (covers register-file write-then-read gap).
REQ-016 stall SHALL be 1 iff id_valid & ex_valid & ex_ctrl[1] & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt).
REQ-017 On an edge with flush=1 the block SHALL load a bubble: ex_valid=0, ex_ctrl=0, other fields don't-care but zeroed; flush has priority over stall.
REQ-018 On an edge with stall=1 and flush=0 the block SHALL load a bubble as REQ-017.
REQ-019 On an edge with id_valid=0 the block SHALL load a bubble.
REQ-020 Otherwise it SHALL load ex_valid=1 and all id_* fields, latency exactly one cycle.
REQ-021 ex_opA priority: ex_rs==0 -> 0 (fwdA=3); mem_regwr & mem_addr==ex_rs -> mem_data (1); wb_regwr & wb_addr==ex_rs -> wb_data (2); else captured A (0). ex_opB identical on ex_rt.
REQ-022 mem_* SHALL win over wb_* when both match (younger result).
REQ-023 Writes with address 0 SHALL never be forwarded or bypassed.
REQ-024 When ex_valid=0, ex_opA/ex_opB still follow REQ-021 (values ignored downstream); stall SHALL be 0.
REQ-025 Stall lasts exactly one cycle per load-use pair: after the bubble, load sits in WB and REQ-021 source 2 supplies its data.

Reset
REQ-026 rst_n=0 SHALL immediately clear ex_valid, ex_ctrl, ex_rs, ex_rt, ex_dst, ex_imm and captured operands to 0, independent of clk.
REQ-027 During reset stall SHALL be 0; ex_opA/ex_opB SHALL be 0 unless mem_*/wb_* forwarding matches register 0 (never, per REQ-023).
REQ-028 First edge after rst_n rises SHALL behave as a normal capture.

Verification
REQ-029 Bypass: wb_regwr=1, wb_addr=5, wb_data=0xDEADBEEF, id_rs=5, id_busA=0x11 -> after edge ex_opA=0xDEADBEEF, ex_fwdA=0 (no later forward).
REQ-030 Double match: ex_rs=3, mem_addr=3 data 0xA, wb_addr=3 data 0xB, both regwr=1 -> ex_opA=0xA, ex_fwdA=1.
REQ-031 Load-use: EX holds lw with ex_dst=8, ex_ctrl[1]=1; ID add with id_rt=8 -> stall=1, next edge ex_valid=0; following edge add captured, stall=0, ex_opB=wb_data when wb_addr=8.
REQ-032 Zero register: ex_rs=0, mem_regwr=1, mem_addr=0, mem_data=0xFF -> ex_opA=0, ex_fwdA=3; lw with ex_dst=0 never stalls.
REQ-033 Flush+stall same cycle -> bubble, ex_ctrl=0; flush alone with id_valid=1 -> ex_valid=0.
REQ-034 Assert rst_n=0 mid-stream between edges -> ex_valid and ex_ctrl drop to 0 before next clk edge; stall=0.
